kernel_buffer_loader: RTL and testbench

KERNEL_BUFFER_LOADER -- requirements
Module: kernel_buffer_loader

---
 rtl/kernel_buffer_loader.sv | 190 +++++++++++++++++++
 tb/tb_kernel_buffer_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_buffer_loader.sv
// Kernel buffer loader: collects SIZE stream words per row into staging lanes
// and writes each completed row to SIZE parallel banks at (base + row) mod DEPTH.
// Optional feature: define KB_LOADER_LAST_CHECK_EN to check s_last framing.
// The dina_0..dina_7 port list assumes SIZE = 8.
module kernel_buffer_loader #(
   parameter  int unsigned SIZE  = 8,
   parameter  int unsigned DEPTH = 32,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = $clog2(SIZE),
   localparam int unsigned DW    = 128
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   num_rows,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   input  logic          s_last,
   output logic          wea,
   output logic [AW-1:0] addra,
   output logic [DW-1:0] dina_0,
   output logic [DW-1:0] dina_1,
   output logic [DW-1:0] dina_2,
   output logic [DW-1:0] dina_3,
   output logic [DW-1:0] dina_4,
   output logic [DW-1:0] dina_5,
   output logic [DW-1:0] dina_6,
   output logic [DW-1:0] dina_7,
   output logic          busy,
   output logic          done,
   output logic          error
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, FINISH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] base_q, base_d;
   logic [AW:0]   rows_q, rows_d;
   logic [AW:0]   row_q, row_d;
   logic [LW-1:0] lane_q, lane_d;
   logic          err_q, err_d;
   logic [DW-1:0] stage_q [SIZE-1];
   logic [DW-1:0] stage_d [SIZE-1];
   logic [DW-1:0] dina_q [SIZE];
   logic [DW-1:0] dina_d [SIZE];
   logic          wea_q, wea_d;
   logic [AW-1:0] addra_q, addra_d;
   logic          s_ready_q, s_ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;

   logic          fire;
   logic          last_lane;
   logic          last_row;
   logic          abort;

`ifndef KB_LOADER_LAST_CHECK_EN
   logic          unused_last;
   assign unused_last = s_last;
`endif

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         rows_q    <= '0;
         row_q     <= '0;
         lane_q    <= '0;
         err_q     <= 1'b0;
         for (int k = 0; k < int'(SIZE) - 1; k++) stage_q[k] <= '0;
         for (int k = 0; k < int'(SIZE); k++) dina_q[k] <= '0;
         wea_q     <= 1'b0;
         addra_q   <= '0;
         s_ready_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         rows_q    <= rows_d;
         row_q     <= row_d;
         lane_q    <= lane_d;
         err_q     <= err_d;
         stage_q   <= stage_d;
         dina_q    <= dina_d;
         wea_q     <= wea_d;
         addra_q   <= addra_d;
         s_ready_q <= s_ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
      end
   end

   // Next-state, counters, staging, and registered output decode
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rows_d    = rows_q;
      row_d     = row_q;
      lane_d    = lane_q;
      err_d     = err_q;
      stage_d   = stage_q;
      dina_d    = dina_q;
      addra_d   = addra_q;
      fire      = s_valid && (state_q == LOAD);
      last_lane = (lane_q == LW'(SIZE - 1));
      last_row  = (row_q == (rows_q - (AW+1)'(1)));
      abort     = 1'b0;

      case (state_q)
         IDLE: begin
            err_d = 1'b0;
            if (start) begin
               if ((num_rows != '0) && (num_rows <= (AW+1)'(DEPTH))) begin
                  base_d  = base_addr;
                  rows_d  = num_rows;
                  row_d   = '0;
                  lane_d  = '0;
                  state_d = LOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end
            end
         end
         LOAD: begin
            if (fire) begin
`ifdef KB_LOADER_LAST_CHECK_EN
               abort = s_last && !(last_lane && last_row);
               if (last_lane && last_row && !s_last) err_d = 1'b1;
`endif
               if (abort) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else if (last_lane) begin
                  // Final lane bypasses staging so the row is written next cycle
                  for (int k = 0; k < int'(SIZE) - 1; k++) dina_d[k] = stage_q[k];
                  dina_d[SIZE-1] = s_data;
                  addra_d        = base_q + row_q[AW-1:0];
                  lane_d         = '0;
                  state_d        = WRITE;
               end else begin
                  for (int k = 0; k < int'(SIZE) - 1; k++) begin
                     if (lane_q == LW'(k)) stage_d[k] = s_data;
                  end
                  lane_d = lane_q + LW'(1);
               end
            end
         end
         WRITE: begin
            row_d   = row_q + (AW+1)'(1);
            state_d = last_row ? FINISH : LOAD;
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      s_ready_d = (state_d == LOAD);
      busy_d    = (state_d != IDLE);
      wea_d     = (state_d == WRITE);
      done_d    = (state_d == FINISH);
      error_d   = (state_d == FINISH) && err_d;
   end

   assign s_ready = s_ready_q;
   assign busy    = busy_q;
   assign wea     = wea_q;
   assign addra   = addra_q;
   assign done    = done_q;
   assign error   = error_q;
   assign dina_0  = dina_q[0];
   assign dina_1  = dina_q[1];
   assign dina_2  = dina_q[2];
   assign dina_3  = dina_q[3];
   assign dina_4  = dina_q[4];
   assign dina_5  = dina_q[5];
   assign dina_6  = dina_q[6];
   assign dina_7  = dina_q[7];

endmodule

// File: tb/tb_kernel_buffer_loader.sv
// Directed bench for kernel_buffer_loader.
module tb_kernel_buffer_loader;

`ifdef KB_LOADER_LAST_CHECK_EN
   localparam bit LC_EN = 1'b1;
`else
   localparam bit LC_EN = 1'b0;
`endif

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [4:0]   base_addr = '0;
   logic [5:0]   num_rows = '0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [127:0] s_data = '0;
   logic         s_last = 1'b0;
   logic         wea;
   logic [4:0]   addra;
   logic [127:0] dina_0, dina_1, dina_2, dina_3, dina_4, dina_5, dina_6, dina_7;
   logic         busy, done, error;
   logic [127:0] dv [8];

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic done_err = 1'b0;
   int rdy_in_wr = 0;
   int xfer_cyc [$];
   int wea_cyc [$];
   logic [4:0] wea_addr [$];
   logic [127:0] wd [$];

   kernel_buffer_loader dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .num_rows(num_rows), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .wea(wea), .addra(addra),
      .dina_0(dina_0), .dina_1(dina_1), .dina_2(dina_2), .dina_3(dina_3),
      .dina_4(dina_4), .dina_5(dina_5), .dina_6(dina_6), .dina_7(dina_7),
      .busy(busy), .done(done), .error(error)
   );

   assign dv[0] = dina_0;
   assign dv[1] = dina_1;
   assign dv[2] = dina_2;
   assign dv[3] = dina_3;
   assign dv[4] = dina_4;
   assign dv[5] = dina_5;
   assign dv[6] = dina_6;
   assign dv[7] = dina_7;

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Passive observer, sampled mid-cycle
   always @(negedge clock) begin
      if (s_valid && s_ready) xfer_cyc.push_back(cyc);
      if (wea) begin
         wea_addr.push_back(addra);
         wea_cyc.push_back(cyc);
         for (int k = 0; k < 8; k++) wd.push_back(dv[k]);
         if (s_ready) rdy_in_wr = rdy_in_wr + 1;
      end
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         done_err = error;
      end
   end

   function automatic logic [127:0] pat(input int tag, input int r, input int k);
      return (128'(tag) << 120) | (128'(r) << 8) | 128'(k + 1);
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic push(input logic [127:0] d, input logic last);
      s_valid = 1'b1; s_data = d; s_last = last;
      for (int t = 0; t < 200; t++) begin
         @(negedge clock);
         if (s_ready) begin
            @(posedge clock); #1;
            s_valid = 1'b0; s_last = 1'b0;
            return;
         end
      end
      compared++; mismatched++;
      $error("FAIL push_timeout: observed no s_ready expected s_ready within 200 cycles");
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic pulse_start(input logic [4:0] b, input logic [5:0] n);
      start = 1'b1; base_addr = b; num_rows = n;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic load(input logic [4:0] b, input int n, input int tag, input bit gaps, input bit drop_last);
      pulse_start(b, 6'(n));
      for (int r = 0; r < n; r++) begin
         for (int k = 0; k < 8; k++) begin
            push(pat(tag, r, k), (r == n - 1) && (k == 7) && !drop_last);
            if (gaps && (k % 3 == 1)) idle(2);
         end
      end
   endtask

   task automatic wait_done(input int prev, input int maxc);
      for (int t = 0; t < maxc; t++) begin
         if (done_cnt > prev) return;
         @(negedge clock);
      end
      if (done_cnt > prev) return;
      compared++; mismatched++;
      $error("FAIL done_timeout: observed no done expected done within %0d cycles", maxc);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_wea"}, 128'(wea), 128'(0));
      chk({tag, "_addra"}, 128'(addra), 128'(0));
      for (int k = 0; k < 8; k++) chk($sformatf("%s_dina%0d", tag, k), dv[k], 128'(0));
      chk({tag, "_s_ready"}, 128'(s_ready), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_done"}, 128'(done), 128'(0));
      chk({tag, "_error"}, 128'(error), 128'(0));
   endtask

   initial begin
      int w0, x0, d0, wd0;

      // Reset state
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk_idle_outputs("reset");
      @(posedge clock); #1;
      reset = 1'b0;
      idle(2);

      // Single row at base 0, words 1..8
      w0 = wea_addr.size(); d0 = done_cnt;
      load(5'd0, 1, 0, 1'b0, 1'b0);
      wait_done(d0, 50);
      chk("r1_wea_count", 128'(wea_addr.size() - w0), 128'(1));
      chk("r1_addr", 128'(wea_addr[w0]), 128'(0));
      for (int k = 0; k < 8; k++) chk($sformatf("r1_dina%0d", k), dv[k], 128'(k + 1));
      chk("r1_done_after_wea", 128'(done_cyc - wea_cyc[w0]), 128'(1));
      chk("r1_error", 128'(done_err), 128'(0));
      @(negedge clock);
      chk("r1_busy_after", 128'(busy), 128'(0));
      chk("r1_done_pulse", 128'(done), 128'(0));
      idle(2);

      // Base 30, 4 rows, wrap and throughput
      w0 = wea_addr.size(); x0 = xfer_cyc.size(); d0 = done_cnt;
      load(5'd30, 4, 1, 1'b0, 1'b0);
      wait_done(d0, 100);
      chk("wrap_wea_count", 128'(wea_addr.size() - w0), 128'(4));
      chk("wrap_addr0", 128'(wea_addr[w0]), 128'(30));
      chk("wrap_addr1", 128'(wea_addr[w0 + 1]), 128'(31));
      chk("wrap_addr2", 128'(wea_addr[w0 + 2]), 128'(0));
      chk("wrap_addr3", 128'(wea_addr[w0 + 3]), 128'(1));
      chk("wrap_first_wea", 128'(wea_cyc[w0] - xfer_cyc[x0]), 128'(8));
      chk("wrap_latency", 128'(done_cyc - xfer_cyc[x0]), 128'(36));
      chk("wrap_row3_lane7", dv[7], pat(1, 3, 7));
      chk("wrap_error", 128'(done_err), 128'(0));
      idle(2);

      // Stalled stream over 2 rows
      w0 = wea_addr.size(); wd0 = wd.size(); d0 = done_cnt;
      load(5'd5, 2, 2, 1'b1, 1'b0);
      wait_done(d0, 200);
      chk("stall_wea_count", 128'(wea_addr.size() - w0), 128'(2));
      chk("stall_addr0", 128'(wea_addr[w0]), 128'(5));
      chk("stall_addr1", 128'(wea_addr[w0 + 1]), 128'(6));
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 8; k++)
            chk($sformatf("stall_r%0d_l%0d", r, k), wd[wd0 + 8 * r + k], pat(2, r, k));
      chk("stall_error", 128'(done_err), 128'(0));
      idle(2);

      // Invalid row counts 0 and 33
      w0 = wea_addr.size(); d0 = done_cnt;
      pulse_start(5'd4, 6'd0);
      wait_done(d0, 10);
      chk("zero_rows_error", 128'(done_err), 128'(1));
      chk("zero_rows_wea", 128'(wea_addr.size() - w0), 128'(0));
      idle(2);
      d0 = done_cnt;
      pulse_start(5'd4, 6'd33);
      wait_done(d0, 10);
      chk("rows33_error", 128'(done_err), 128'(1));
      chk("rows33_wea", 128'(wea_addr.size() - w0), 128'(0));
      idle(2);

      // Start pulsed during a load is ignored
      w0 = wea_addr.size(); d0 = done_cnt;
      pulse_start(5'd3, 6'd1);
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin start = 1'b1; base_addr = 5'd20; num_rows = 6'd2; end
         push(pat(3, 0, k), k == 7);
         start = 1'b0;
      end
      wait_done(d0, 20);
      chk("busy_start_wea_count", 128'(wea_addr.size() - w0), 128'(1));
      chk("busy_start_addr", 128'(wea_addr[w0]), 128'(3));
      chk("busy_start_error", 128'(done_err), 128'(0));
      idle(3);
      chk("busy_start_idle", 128'(busy), 128'(0));
      chk("busy_start_done_count", 128'(done_cnt - d0), 128'(1));

      // Early s_last on lane 5 of row 0
      w0 = wea_addr.size(); x0 = xfer_cyc.size(); d0 = done_cnt;
      pulse_start(5'd7, 6'd1);
      for (int k = 0; k < 8; k++) begin
         if (LC_EN && k > 5) break;
         push(pat(4, 0, k), k == 5);
      end
      wait_done(d0, 20);
      chk("early_last_wea", 128'(wea_addr.size() - w0), LC_EN ? 128'(0) : 128'(1));
      chk("early_last_error", 128'(done_err), 128'(LC_EN));
      if (LC_EN) chk("early_last_timing", 128'(done_cyc - xfer_cyc[x0 + 5]), 128'(1));
      idle(2);

      // Final word without s_last
      w0 = wea_addr.size(); d0 = done_cnt;
      load(5'd9, 1, 6, 1'b0, 1'b1);
      wait_done(d0, 20);
      chk("missing_last_wea", 128'(wea_addr.size() - w0), 128'(1));
      chk("missing_last_error", 128'(done_err), 128'(LC_EN));
      idle(2);

      // Reset after lane 3 of row 1
      w0 = wea_addr.size(); d0 = done_cnt;
      pulse_start(5'd10, 6'd3);
      for (int k = 0; k < 8; k++) push(pat(7, 0, k), 1'b0);
      for (int k = 0; k < 4; k++) push(pat(7, 1, k), 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk_idle_outputs("midreset");
      @(posedge clock); #1;
      reset = 1'b0;
      idle(12);
      chk("midreset_wea_count", 128'(wea_addr.size() - w0), 128'(1));
      chk("midreset_no_done", 128'(done_cnt - d0), 128'(0));
      w0 = wea_addr.size();
      load(5'd2, 1, 8, 1'b0, 1'b0);
      wait_done(d0, 30);
      chk("post_reset_wea_count", 128'(wea_addr.size() - w0), 128'(1));
      chk("post_reset_addr", 128'(wea_addr[w0]), 128'(2));
      chk("post_reset_lane0", dv[0], pat(8, 0, 0));
      chk("post_reset_lane7", dv[7], pat(8, 0, 7));
      chk("post_reset_error", 128'(done_err), 128'(0));
      idle(2);

      // Full 32-row load
      w0 = wea_addr.size(); d0 = done_cnt;
      load(5'd0, 32, 9, 1'b0, 1'b0);
      wait_done(d0, 400);
      chk("full_wea_count", 128'(wea_addr.size() - w0), 128'(32));
      chk("full_last_addr", 128'(wea_addr[wea_addr.size() - 1]), 128'(31));
      chk("full_last_lane3", dv[3], pat(9, 31, 3));
      chk("full_error", 128'(done_err), 128'(0));
      chk("ready_low_in_write", 128'(rdy_in_wr), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
